// File: rtl/std_fp_accum_pipe.sv
// Unsigned fixed-point accumulator with go/done handshake: sums len valid beats into a
// guard-widened accumulator, then saturates the total back to the WIDTH-bit format.
module std_fp_accum_pipe #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned INT_WIDTH  = 16,
   parameter int unsigned FRAC_WIDTH = 16,
   parameter int unsigned GUARD      = 8,
   parameter int unsigned LEN_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 go,
   input  logic [LEN_WIDTH-1:0] len,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     in,
   output logic [WIDTH-1:0]     out,
   output logic                 overflow,
   output logic                 done
);

   localparam int unsigned ACC_W = WIDTH + GUARD;

   if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_bad_format
      $error("std_fp_accum_pipe: INT_WIDTH + FRAC_WIDTH must equal WIDTH");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACC   = 2'd1,
      S_FINAL = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e               state_q;
   logic [ACC_W-1:0]     acc_q;
   logic [LEN_WIDTH-1:0] count_q;
   logic [LEN_WIDTH-1:0] len_q;

   logic [LEN_WIDTH-1:0] count_inc_c;
   logic [ACC_W-1:0]     acc_sum_c;
   logic                 acc_ovf_c;

   // Same-format operands align without shifting; the sum is exact.
   assign count_inc_c = count_q + LEN_WIDTH'(1);
   assign acc_sum_c   = acc_q + ACC_W'(in);
   assign acc_ovf_c   = |acc_q[ACC_W-1:WIDTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         count_q  <= '0;
         len_q    <= '0;
         out      <= '0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (go) begin
                  len_q   <= len;
                  acc_q   <= '0;
                  count_q <= '0;
                  state_q <= (len == '0) ? S_FINAL : S_ACC;
               end
            end
            S_ACC: begin
               if (!go) begin
                  state_q <= S_IDLE;
               end else if (in_valid) begin
                  acc_q   <= acc_sum_c;
                  count_q <= count_inc_c;
                  if (count_inc_c == len_q) begin
                     state_q <= S_FINAL;
                  end
               end
            end
            S_FINAL: begin
               // An abort here leaves out/overflow at their pre-operation values.
               if (!go) begin
                  state_q <= S_IDLE;
               end else begin
                  out      <= acc_ovf_c ? '1 : acc_q[WIDTH-1:0];
                  overflow <= acc_ovf_c;
                  done     <= 1'b1;
                  state_q  <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/std_fp_accum_pipe.md
Name: std_fp_accum_pipe

Overview:
- Unsigned fixed-point accumulator that sits directly downstream of the pipelined unsigned fixed-point multiplier.
- Sums a run of `len` products, presented one per valid beat, into a widened accumulator with guard bits.
- Saturates the sum back to the WIDTH-bit fixed-point format with INT_WIDTH integer and FRAC_WIDTH fraction bits.
- Uses the standard go/done handshake, so it can close dot-product and MAC loops in generated designs.

Parameters:
- WIDTH, 32, bit width of input products and of the result
- INT_WIDTH, 16, integer bits of the fixed-point format (informational; format is preserved end to end)
- FRAC_WIDTH, 16, fraction bits; INT_WIDTH + FRAC_WIDTH must equal WIDTH, otherwise elaboration $error
- GUARD, 8, extra integer bits in the accumulator (accumulator width = WIDTH + GUARD)
- LEN_WIDTH, 8, width of the term-count input

Ports:
- clk, input, 1, clock; all state updates on posedge
- reset, input, 1, synchronous active-high reset
- go, input, 1, start/hold request; must stay high until done is seen
- len, input, LEN_WIDTH, number of terms to accumulate; sampled when an operation starts
- in_valid, input, 1, qualifies `in` for one accumulation beat
- in, input, WIDTH, unsigned fixed-point product (same format as result)
- out, output, WIDTH, saturated sum
- overflow, output, 1, high if the sum exceeded 2^WIDTH-1
- done, output, 1, single-cycle completion pulse

Behaviour:
- Reset (synchronous, sampled at posedge):
  - state=IDLE; accumulator, count, len_r, out, overflow and done all cleared to 0.
  - Reset takes priority over every other event, including mid-operation; no done is emitted for the aborted run.
- States: IDLE, ACC, FINAL, DONE.
  - done = 1 exactly while state==DONE. It is registered, with no combinational path from inputs.
- IDLE:
  - in_valid is ignored.
  - On posedge with go=1: len_r<=len, acc<=0, count<=0.
  - Next state is FINAL if len==0, else ACC.
  - out and overflow hold their previous values until FINAL.
- ACC:
  - On posedge with in_valid=1: acc <= acc + zero-extend(in); count <= count+1.
  - When the accepted beat makes count+1==len_r, next state is FINAL.
  - in_valid=0 cycles are bubbles: no change, unlimited length.
- FINAL:
  - If acc[WIDTH+GUARD-1:WIDTH] != 0: out <= all ones, overflow <= 1.
  - Otherwise: out <= acc[WIDTH-1:0], overflow <= 0.
  - Next state is DONE. in_valid is ignored.
- DONE: next state is IDLE unconditionally.
  - If go is still high in IDLE on the following edge, a new operation starts. This matches the pipe primitives, which restart while go is held.
- Latency:
  - The last valid beat is accepted at edge k. FINAL spans edge k to k+1; done and the final out are visible in the cycle after edge k+1.
  - With len==0, done is high in the cycle after the second edge following go sampled.
- Accumulator overflow:
  - With len ≤ 2^GUARD, the accumulator cannot wrap.
  - Beyond that the accumulator wraps modulo 2^(WIDTH+GUARD). This is documented as out of contract and is not detected.
- go dropped (sampled 0) in ACC or FINAL: abort to IDLE.
  - No done pulse; out and overflow keep their pre-operation values.
- go=0 while in DONE: done still pulses that cycle, then IDLE.
- Fixed-point alignment: the sum of same-format values needs no shift. No rounding is performed; fraction bits pass through exactly.
- Beats presented with in_valid=1 in IDLE, FINAL or DONE are dropped and never counted.

Test Plan:
- Basic sum (WIDTH=32, FRAC=16):
  - Stimulus: go=1, len=3, three back-to-back beats of in=0x00018000 (1.5).
  - Required: out=0x00048000 (4.5), overflow=0, done high for exactly one cycle, 2 cycles after the third beat edge.
- Bubbles:
  - Stimulus: len=4, beats of 0x00010000 each separated by 0–3 idle cycles; extra in_valid beats after the 4th.
  - Required: out=0x00040000; the extra beats are ignored.
- Saturation:
  - Stimulus: len=2, in=0xFFFF0000 twice (raw sum 0x1FFFE0000).
  - Required: out=0xFFFFFFFF, overflow=1.
  - Follow-up: a later run with len=1, in=0x00000001 gives out=0x00000001 and clears overflow to 0.
- Zero length:
  - Stimulus: go=1, len=0, in_valid toggling.
  - Required: out=0, overflow=0, done pulse in the cycle after the second edge following go; no beats consumed.
- Abort and reset:
  - Stimulus: go dropped after 2 of 5 beats.
  - Required: no done; out keeps its previous value (e.g. 0x00048000).
  - Then: a new run len=1, in=0x00020000 gives out=0x00020000.
  - Reset asserted mid-run: out=0, overflow=0, done=0 on the next edge, state IDLE.
- Held go:
  - Stimulus: go kept high across done, with len=1 and a beat of 0x00008000 presented each time.
  - Required: a second operation starts immediately after DONE, and done pulses again 3 cycles later.
